// File: rtl/mux32_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared mux32 datapath and
// presents the chosen requester's word downstream via valid/ready, with bounded bursts.
module mux32_rr_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] req,
    input  logic        out_ready,
    output logic [4:0]  select,
    output logic [31:0] grant,
    output logic        out_valid,
    output logic [7:0]  beat_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    state_t      state_q, state_d;
    logic [4:0]  ptr_q, ptr_d;
    logic [4:0]  select_q, select_d;
    logic [31:0] grant_q, grant_d;
    logic [7:0]  beat_q, beat_d;

    logic        accept;
    logic        release_now;
    logic [4:0]  next_ptr;
    logic [31:0] others;
    logic [31:0] cand;
    logic [5:0]  pick_idle;
    logic [5:0]  pick_rel;

    // Returns {found, index} of the first set bit scanning upward from p, wrapping mod 32.
    function automatic logic [5:0] rr_pick(input logic [31:0] r, input logic [4:0] p);
        logic [5:0] res;
        logic [4:0] idx;
        res = '0;
        // Scan downward so the closest index to p is the last one written.
        for (int k = 31; k >= 0; k--) begin
            idx = p + 5'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            select_q <= '0;
            grant_q  <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            select_q <= select_d;
            grant_q  <= grant_d;
            beat_q   <= beat_d;
        end
    end

    assign accept      = (state_q == GRANT) && req[select_q] && out_ready;
    assign release_now = (state_q == GRANT) &&
                         (!req[select_q] || (accept && (beat_q == LAST_BEAT)));
    assign next_ptr    = select_q + 5'd1;
    // The outgoing holder competes only if nobody else is asking.
    assign others      = req & ~(32'b1 << select_q);
    assign cand        = (others == '0) ? req : others;
    assign pick_idle   = rr_pick(req, ptr_q);
    assign pick_rel    = rr_pick(cand, next_ptr);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        select_d = select_q;
        grant_d  = grant_q;
        beat_d   = beat_q;
        case (state_q)
            IDLE: begin
                if (pick_idle[5]) begin
                    state_d  = GRANT;
                    select_d = pick_idle[4:0];
                    grant_d  = 32'b1 << pick_idle[4:0];
                    beat_d   = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d = next_ptr;
                    if (pick_rel[5]) begin
                        select_d = pick_rel[4:0];
                        grant_d  = 32'b1 << pick_rel[4:0];
                        beat_d   = '0;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        beat_d  = '0;
                    end
                end else if (accept) begin
                    beat_d = beat_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        out_valid  = (state_q == GRANT) && req[select_q];
        select     = select_q;
        grant      = grant_q;
        beat_count = beat_q;
    end

endmodule

// File: tb/tb_mux32_rr_arbiter.sv
// Randomized scoreboard bench for mux32_rr_arbiter against a round-robin
// reference model written directly from the arbitration rules.
module tb_mux32_rr_arbiter;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] req = '0;
    logic        out_ready = 1'b0;
    logic [4:0]  select;
    logic [31:0] grant;
    logic        out_valid;
    logic [7:0]  beat_count;

    mux32_rr_arbiter #(.MAX_BURST(MB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .out_ready  (out_ready),
        .select     (select),
        .grant      (grant),
        .out_valid  (out_valid),
        .beat_count (beat_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  sel;
        logic [31:0] gnt;
        logic        vld;
        logic [7:0]  beat;
        logic        gst;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: holder index, whether someone holds a grant,
    // rotating priority start and beats taken in the current grant.
    bit m_gst;
    int m_ptr;
    int m_sel;
    int m_cnt;

    function automatic int search(input logic [31:0] r, input int p);
        int idx;
        for (int k = 0; k < 32; k++) begin
            idx = (p + k) % 32;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gst = 1'b0;
        m_ptr = 0;
        m_sel = 0;
        m_cnt = 0;
    endtask

    task automatic step(input logic [31:0] r, input logic rdy);
        exp_t        e;
        logic [31:0] m;
        bit          acc;
        int          w;
        @(negedge clk);
        req = r;
        out_ready = rdy;
        #1;
        e.gst  = m_gst;
        e.sel  = m_sel[4:0];
        e.gnt  = m_gst ? (32'b1 << m_sel) : 32'b0;
        e.vld  = m_gst && r[m_sel];
        e.beat = m_cnt[7:0];
        sbq.push_back(e);
        if (!m_gst) begin
            if (r != 0) begin
                m_gst = 1'b1;
                m_sel = search(r, m_ptr);
                m_cnt = 0;
            end
        end else begin
            acc = e.vld && rdy;
            if (!r[m_sel] || (acc && m_cnt == MB - 1)) begin
                m_ptr = (m_sel + 1) % 32;
                m = r & ~(32'b1 << m_sel);
                if (m == 0) m = r;
                w = search(m, m_ptr);
                if (w >= 0) begin
                    m_sel = w;
                end else begin
                    m_gst = 1'b0;
                end
                m_cnt = 0;
            end else if (acc) begin
                m_cnt++;
            end
        end
    endtask

    // Monitor: compares whatever the DUT presents against the oldest expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("out_valid", 32'(out_valid), 32'(e.vld));
                check("grant", grant, e.gnt);
                check("select", 32'(select), 32'(e.sel));
                if (e.gst) check("beat_count", 32'(beat_count), 32'(e.beat));
            end
        end
    end

    initial begin : stimulus
        logic [31:0] cur;
        logic        rdy;
        model_reset();
        #12;
        check("rst_grant", grant, 32'h0);
        check("rst_select", 32'(select), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_beat", 32'(beat_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Lone requester: four beats then immediate re-grant to itself.
        for (int i = 0; i < 12; i++) step(32'h0000_0010, 1'b1);
        // Wrap-around rotation between 31 and 0.
        for (int i = 0; i < 14; i++) step(32'h8000_0001, 1'b1);
        // Early release of 3 with 7 waiting.
        step(32'h0000_0008, 1'b1);
        step(32'h0000_0088, 1'b1);
        for (int i = 0; i < 3; i++) step(32'h0000_0080, 1'b1);
        // Backpressure mid-burst.
        step(32'h0000_0400, 1'b1);
        step(32'h0000_0400, 1'b1);
        for (int i = 0; i < 5; i++) step(32'h0000_0400, 1'b0);
        for (int i = 0; i < 6; i++) step(32'h0000_0400, 1'b1);
        // Holder drops right at its burst limit with 9 waiting.
        for (int i = 0; i < 4; i++) step(32'h0000_0020, 1'b1);
        for (int i = 0; i < 3; i++) step(32'h0000_0200, 1'b1);
        step(32'h0000_0000, 1'b1);
        step(32'h0000_0000, 1'b1);

        cur = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 4))
                    0: cur = '0;
                    1: cur = 32'b1 << $urandom_range(0, 31);
                    2: cur = $urandom;
                    default: cur = $urandom & $urandom & $urandom;
                endcase
            end
            rdy = ($urandom_range(0, 3) != 0);
            step(cur, rdy);
        end

        // Asynchronous reset while 12 holds the grant mid-burst.
        for (int i = 0; i < 3; i++) step(32'h0000_1000, 1'b1);
        @(posedge clk);
        #3;
        check("pre_rst_grant", grant, 32'h0000_1000);
        check("pre_rst_beat", 32'(beat_count), 32'd2);
        rst_n = 1'b0;
        #1;
        check("arst_grant", grant, 32'h0);
        check("arst_valid", 32'(out_valid), 32'h0);
        check("arst_beat", 32'(beat_count), 32'h0);
        check("arst_select", 32'(select), 32'h0);
        req = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step(32'h0050_0400, 1'b1);
        for (int i = 0; i < 200; i++) begin
            step($urandom & $urandom, ($urandom_range(0, 2) != 0));
        end

        @(negedge clk);
        #3;
        check("sb_drain", 32'(sbq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
